// File: rtl/alu_core.sv
// Registered 32-bit execute-stage ALU: add/sub/logic/lui/shift selected by aluc,
// with the result and its zero flag captured together on every rising edge.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             z
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] r_d, r_q;
  logic             z_d, z_q;

  assign shamt = a[4:0];

  // aluc[1:0] picks the operation group; aluc[2] (and aluc[3] for shifts) picks within it.
  always_comb begin
    res = '0;
    unique case (aluc[1:0])
      2'b00: res = aluc[2] ? (a - b) : (a + b);
      2'b01: res = aluc[2] ? (a | b) : (a & b);
      2'b10: res = aluc[2] ? {b[15:0], {(WIDTH-16){1'b0}}} : (a ^ b);
      2'b11: begin
        unique case (aluc[3:2])
          2'b00:   res = b << shamt;
          2'b01:   res = b >> shamt;
          2'b11:   res = $unsigned($signed(b) >>> shamt);
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    r_d = res;
    z_d = (res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      z_q <= 1'b1;
    end else begin
      r_q <= r_d;
      z_q <= z_d;
    end
  end

  assign r = r_q;
  assign z = z_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: each step drives operands at the falling edge and
// checks r/z one rising edge later against hand-computed values.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        z;

  int checks;
  int failures;

  logic [31:0] exp_q[$];

  alu_core #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .aluc (aluc),
    .r    (r),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, then compare after the capturing edge.
  task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                      input logic [3:0] op, input logic [31:0] exp_r, input logic exp_z);
    logic [31:0] er;
    logic [31:0] ez;
    @(negedge clk);
    a    = ta;
    b    = tb;
    aluc = op;
    exp_q.push_back(exp_r);
    exp_q.push_back({31'd0, exp_z});
    @(posedge clk);
    #1;
    er = exp_q.pop_front();
    ez = exp_q.pop_front();
    check({tag, "_r"}, r, er);
    check({tag, "_z"}, {31'd0, z}, ez);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = 32'd10;
    b        = 32'd3;
    aluc     = 4'b0000;

    // Reset held across edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_r", r, 32'd0);
    check("rst_hold_z", {31'd0, z}, 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_r", r, 32'd13);
    check("rst_rel_z", {31'd0, z}, 32'd0);

    // Arithmetic / logic
    step("add",   32'd10, 32'd3, 4'b0000, 32'd13, 1'b0);
    step("sub",   32'd10, 32'd3, 4'b0100, 32'd7,  1'b0);
    step("and",   32'd10, 32'd3, 4'b0001, 32'd2,  1'b0);
    step("or",    32'd10, 32'd3, 4'b0101, 32'd11, 1'b0);
    step("xor",   32'd10, 32'd3, 4'b0010, 32'd9,  1'b0);
    step("add_al",32'd10, 32'd3, 4'b1000, 32'd13, 1'b0);
    step("sub_al",32'd10, 32'd3, 4'b1100, 32'd7,  1'b0);
    step("or_al", 32'd10, 32'd3, 4'b1101, 32'd11, 1'b0);

    // LUI / shifts
    step("lui",   32'd10, 32'd3, 4'b0110, 32'h0003_0000, 1'b0);
    step("lui_b", 32'hFFFF_FFFF, 32'hABCD_1234, 4'b1110, 32'h1234_0000, 1'b0);
    step("sll",   32'd10, 32'd3, 4'b0011, 32'd3072, 1'b0);
    step("srl",   32'd10, 32'd3, 4'b0111, 32'd0, 1'b1);
    step("sra",   32'd10, 32'd3, 4'b1111, 32'd0, 1'b1);
    step("unused",32'd10, 32'd3, 4'b1011, 32'd0, 1'b1);

    // Sign fill, wrap, shift boundaries
    step("sra_neg", 32'd4, 32'h8000_0000, 4'b1111, 32'hF800_0000, 1'b0);
    step("srl_neg", 32'd4, 32'h8000_0000, 4'b0111, 32'h0800_0000, 1'b0);
    step("add_wrap",32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1);
    step("sub_neg", 32'd3, 32'd10, 4'b0100, 32'hFFFF_FFF9, 1'b0);
    step("sll_hi",  32'h25, 32'd1, 4'b0011, 32'd32, 1'b0);
    step("sll_0",   32'hFFFF_FFE0, 32'hDEAD_BEEF, 4'b0011, 32'hDEAD_BEEF, 1'b0);
    step("sra_0",   32'd0, 32'h8765_4321, 4'b1111, 32'h8765_4321, 1'b0);
    step("sll_31",  32'd31, 32'd3, 4'b0011, 32'h8000_0000, 1'b0);
    step("sra_31",  32'd31, 32'h8000_0000, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    step("srl_31",  32'd31, 32'h8000_0000, 4'b0111, 32'd1, 1'b0);

    // Zero flag tracks the captured result
    step("zero_sub",32'h1234, 32'h1234, 4'b0100, 32'd0, 1'b1);
    step("zero_add",32'h1234, 32'h1234, 4'b0000, 32'h2468, 1'b0);

    // Only the aluc value at the edge matters
    @(negedge clk);
    a    = 32'd10;
    b    = 32'd3;
    aluc = 4'b0100;
    #2;
    aluc = 4'b0000;
    @(posedge clk);
    #1;
    check("mid_aluc_r", r, 32'd13);
    check("mid_aluc_z", {31'd0, z}, 32'd0);

    // Async reset between edges clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_r", r, 32'd0);
    check("async_rst_z", {31'd0, z}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 32'd10, 32'd3, 4'b0101, 32'd11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
